pe_accumulator: RTL and testbench
=================================

# pe_accumulator

Accumulates a fixed-length stream of unsigned 16-bit products into a saturating wide sum, then presents the dot-product result on a valid/ready output. Sits directly downstream of the PE's 8x8 multiplier: it consumes the multiplier's registered product each cycle the product is flagged valid. The output feeds the PE's writeback/output buffer.

## Interface
- `ACC_W`, 24: accumulator and result width. Must be ≥ 16.
- `LEN_W`, 8: width of the vector-length field.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request a new accumulation. Sampled only in IDLE.
- `len` input LEN_W: number of products to sum. Sampled with `start`.
- `prod_valid` input 1: `prod_in` holds a product to accumulate this cycle.
- `prod_in` input 16: unsigned product from the multiplier.
- `out_ready` input 1: consumer accepts the result.
- `out_valid` output 1: `acc_out` holds a completed result.
- `acc_out` output ACC_W: accumulated sum, saturated.
- `overflow` output 1: saturation occurred during the current or last job.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states are IDLE, ACCUM and HOLD.
- **IDLE**
  - `start`=1 with `len`≠0: clear acc, count and overflow; latch `len`; go to ACCUM.
  - `start`=1 with `len`=0: clear acc and overflow; go directly to HOLD (result 0).
  - `prod_valid` is ignored.
- **ACCUM**
  - Each cycle with `prod_valid`=1: acc ← sat(acc + zero-extended `prod_in`), and count increments.
  - The beat that makes count == latched len moves the FSM to HOLD.
  - Cycles with `prod_valid`=0 hold all state.
  - `start` is ignored.
- **HOLD**
  - `out_valid`=1 and `acc_out` stays stable.
  - When `out_valid` and `out_ready` are both 1, go to IDLE.
  - `prod_valid` and `start` are ignored, including a `start` on the handshake cycle.
- **Arithmetic**
  - Compute an ACC_W+1-bit sum.
  - If the carry bit is set, acc ← 2^ACC_W−1 and `overflow` ← 1 (sticky until the next accepted `start`).
  - `acc_out` = acc register, driven directly with no output mux logic.
- `busy` = (state ≠ IDLE).

## Timing
- **Reset values:** state=IDLE, acc=0, count=0, `acc_out`=0, `out_valid`=0, `overflow`=0, `busy`=0.
- **Reset mid-operation:** an asserted `rst_n`=0 in any state returns everything to reset values immediately (asynchronous). The in-flight job is discarded.
- **Start:** `start` at edge t → `busy`=1 after edge t. The first product can be accepted at edge t+1.
- **Last product:** the last product accepted at edge k → `out_valid`=1 and final `acc_out` after edge k. Latency is 1 cycle from that beat.
- **len=0:** `start` at edge t → `out_valid`=1 after edge t.
- **Handshake:** accepted at edge h → `out_valid`=0 and `busy`=0 after edge h. The earliest new `start` is sampled at edge h+1.
- **Backpressure:** `out_ready` held low keeps HOLD indefinitely. Products arriving then are dropped; upstream must gate the multiplier's `en` with `busy`/state.
- **Throughput:** one product per cycle. Back-to-back jobs cost ≥2 idle cycles (handshake cycle plus start cycle).

## Structure
- Shared package `pe_pkg`:
  - state enum `acc_state_t` with values IDLE, ACCUM, HOLD;
  - default `ACC_W`;
  - product width constant `PROD_W`=16.
- One sub-module, `sat_add`: parameterised unsigned saturating adder with a saturated flag.
- FSM, counter and registers live in `pe_accumulator`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ACCUM after 3 beats → all outputs 0 and state IDLE. After release, `start` with len=2, products 5, 7 → `acc_out`=12.
- **Basic dot product:** len=4, products 255×255=65025 four times with gaps in `prod_valid` → `out_valid` one cycle after the 4th beat, `acc_out`=260100, `overflow`=0.
- **Saturation:** ACC_W=16, len=2, products 65025 and 1000 → `acc_out`=65535, `overflow`=1. A following job with len=1, product 3 → `acc_out`=3, `overflow`=0.
- **len=0:** `start` with len=0 → `out_valid` the next cycle with `acc_out`=0. A `prod_valid` pulse in that window does not change the result.
- **Backpressure:** len=1, product 9, `out_ready`=0 for 10 cycles while `start` and `prod_valid` toggle → `acc_out` stays 9 and `out_valid` stays 1. Raising `out_ready` → exactly one handshake, then IDLE.
- **Start during busy:** `start` asserted in ACCUM and on the handshake cycle → both ignored. Only the first job's result is produced.

Source files
------------

// File: rtl/pe_accumulator_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | pe_pkg : shared types and constants for the PE accumulator    |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int DEFAULT_ACC_W = 24;
  localparam int PROD_W        = 16;

endpackage
`default_nettype wire

// File: rtl/pe_accumulator_if.sv
`default_nettype none
// +---------------------------------------------------------------+
// | pe_accumulator_if : start/product/result handshake bundle     |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
interface pe_accumulator_if #(
  parameter int ACC_W = pe_pkg::DEFAULT_ACC_W,
  parameter int LEN_W = 8
);
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic                      prod_valid;
  logic [pe_pkg::PROD_W-1:0] prod_in;
  logic                      out_ready;
  logic                      out_valid;
  logic [ACC_W-1:0]          acc_out;
  logic                      overflow;
  logic                      busy;

  modport master (
    output start, len, prod_valid, prod_in, out_ready,
    input  out_valid, acc_out, overflow, busy
  );

  modport slave (
    input  start, len, prod_valid, prod_in, out_ready,
    output out_valid, acc_out, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/pe_accumulator_sat_add.sv
`default_nettype none
// +---------------------------------------------------------------+
// | sat_add : unsigned saturating adder with saturation flag      |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
module sat_add #(
  parameter int W   = 24,
  parameter int B_W = 16
) (
  input  wire logic [W-1:0]   i_a,
  input  wire logic [B_W-1:0] i_b,
  output logic      [W-1:0]   o_sum,
  output logic                o_sat
);
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {{(W + 1 - B_W){1'b0}}, i_b};
  assign o_sat  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
endmodule
`default_nettype wire

// File: rtl/pe_accumulator.sv
`default_nettype none
// +---------------------------------------------------------------+
// | pe_accumulator : saturating dot-product accumulator with a    |
// | valid/ready result port. rev 1.0                              |
// +---------------------------------------------------------------+
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int LEN_W = 8
) (
  input wire logic       clk,
  input wire logic       rst_n,
  pe_accumulator_if.slave bus
);
  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic             r_overflow;
  logic             r_out_valid;

  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic [LEN_W-1:0] w_count_nxt;

  sat_add #(
    .W   (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (bus.prod_in),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  assign w_count_nxt = r_count + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_len      <= bus.len;
            if (bus.len != '0) begin
              r_state <= ACCUM;
            end else begin
              // Empty vector: result is the cleared accumulator.
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.prod_valid) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            if (w_sat) r_overflow <= 1'b1;
            if (w_count_nxt == r_len) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_out   = r_acc;
  assign bus.out_valid = r_out_valid;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_pe_accumulator.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_pe_accumulator : scoreboard bench for pe_accumulator       |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
module tb_pe_accumulator;
  logic clk;
  logic rst_n;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests;
  int   n_fail;

  pe_accumulator_if #(.ACC_W(24), .LEN_W(8)) a ();
  pe_accumulator_if #(.ACC_W(16), .LEN_W(8)) b ();

  pe_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  pe_accumulator #(.ACC_W(16), .LEN_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboards: every accepted result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && a.out_valid && a.out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_acc_out", 32'(a.acc_out), e.acc);
        chk("a_overflow", 32'(a.overflow), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b.out_valid && b.out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_acc_out", 32'(b.acc_out), e.acc);
        chk("b_overflow", 32'(b.overflow), 32'(e.ovf));
      end
    end
  end

  task automatic push_exp(input bit sel, input logic [31:0] acc, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic do_start(input bit sel, input int l);
    if (sel) begin b.start = 1'b1; b.len = 8'(l); end
    else     begin a.start = 1'b1; a.len = 8'(l); end
    @(posedge clk); #1;
    if (sel) b.start = 1'b0;
    else     a.start = 1'b0;
  endtask

  task automatic feed(input bit sel, input int p);
    if (sel) begin b.prod_valid = 1'b1; b.prod_in = 16'(p); end
    else     begin a.prod_valid = 1'b1; a.prod_in = 16'(p); end
    @(posedge clk); #1;
    if (sel) b.prod_valid = 1'b0;
    else     a.prod_valid = 1'b0;
  endtask

  task automatic gap();
    a.prod_in = 16'hBEEF;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (a.out_valid) seen = 1'b1;
    end
    if (!seen) chk("a_wait_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a.start = 0; a.len = 0; a.prod_valid = 0; a.prod_in = 0; a.out_ready = 1;
    b.start = 0; b.len = 0; b.prod_valid = 0; b.prod_in = 0; b.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc_out", 32'(a.acc_out), 0);
    chk("rst_out_valid", 32'(a.out_valid), 0);
    chk("rst_overflow", 32'(a.overflow), 0);
    chk("rst_busy", 32'(a.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an accumulation discards the job.
    do_start(0, 5);
    feed(0, 10); feed(0, 10); feed(0, 10);
    chk("mid_busy", 32'(a.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc_out", 32'(a.acc_out), 0);
    chk("mid_rst_out_valid", 32'(a.out_valid), 0);
    chk("mid_rst_busy", 32'(a.busy), 0);
    chk("mid_rst_overflow", 32'(a.overflow), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(0, 12, 0);
    do_start(0, 2);
    feed(0, 5); feed(0, 7);
    chk("post_rst_acc", 32'(a.acc_out), 12);
    @(posedge clk); #1;

    // Basic dot product with gaps between beats.
    push_exp(0, 260100, 0);
    do_start(0, 4);
    chk("start_busy", 32'(a.busy), 1);
    feed(0, 65025); gap();
    feed(0, 65025); gap();
    feed(0, 65025);
    chk("basic_not_valid_early", 32'(a.out_valid), 0);
    gap();
    feed(0, 65025);
    chk("basic_valid_latency", 32'(a.out_valid), 1);
    chk("basic_acc", 32'(a.acc_out), 260100);
    @(posedge clk); #1;
    chk("basic_idle_after_hs", 32'(a.busy), 0);

    // Saturation on the 16-bit instance, then overflow clears on the next job.
    push_exp(1, 65535, 1);
    do_start(1, 2);
    feed(1, 65025); feed(1, 1000);
    chk("sat_acc", 32'(b.acc_out), 65535);
    chk("sat_ovf", 32'(b.overflow), 1);
    @(posedge clk); #1;
    push_exp(1, 3, 0);
    do_start(1, 1);
    chk("sat_ovf_cleared", 32'(b.overflow), 0);
    feed(1, 3);
    chk("sat_next_acc", 32'(b.acc_out), 3);
    @(posedge clk); #1;

    // len=0 gives an immediate zero result; products in the window are ignored.
    a.out_ready = 1'b0;
    push_exp(0, 0, 0);
    do_start(0, 0);
    chk("len0_valid", 32'(a.out_valid), 1);
    chk("len0_acc", 32'(a.acc_out), 0);
    feed(0, 77);
    chk("len0_acc_after_prod", 32'(a.acc_out), 0);
    a.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("len0_valid_drop", 32'(a.out_valid), 0);

    // Backpressure: result held while start/prod_valid toggle.
    a.out_ready = 1'b0;
    push_exp(0, 9, 0);
    do_start(0, 1);
    feed(0, 9);
    for (int i = 0; i < 10; i++) begin
      a.start      = i[0];
      a.len        = 8'd1;
      a.prod_valid = ~i[0];
      a.prod_in    = 16'd100;
      @(negedge clk);
      chk("bp_acc", 32'(a.acc_out), 9);
      chk("bp_valid", 32'(a.out_valid), 1);
      @(posedge clk); #1;
    end
    a.start = 1'b0; a.prod_valid = 1'b0;
    a.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_after_hs", 32'(a.out_valid), 0);
    chk("bp_busy_after_hs", 32'(a.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stays_idle", 32'(a.busy), 0);

    // Start during ACCUM and on the handshake cycle must be ignored.
    a.out_ready = 1'b0;
    push_exp(0, 6, 0);
    do_start(0, 3);
    feed(0, 1);
    a.start = 1'b1; a.len = 8'd1;
    feed(0, 2);
    a.start = 1'b0;
    feed(0, 3);
    wait_valid(5);
    @(posedge clk); #1;
    a.out_ready = 1'b1;
    a.start = 1'b1; a.len = 8'd1;
    @(posedge clk); #1;
    a.start = 1'b0;
    chk("hs_start_busy", 32'(a.busy), 0);
    chk("hs_start_valid", 32'(a.out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hs_start_still_idle", 32'(a.busy), 0);

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
